// File: rtl/bowling_pkg.sv
// Shared constants and FSM encoding for the bowling roll sequencer.
// Ports: none (package only).
package bowling_pkg;

    localparam int MAX_PINS   = 10;
    localparam int NUM_FRAMES = 10;
    localparam int PIN_W      = 4;
    localparam int SCORE_W    = 11;

    typedef enum logic [2:0] {
        F_R1,
        F_R2,
        T_R1,
        T_R2,
        T_R3,
        DONE
    } state_t;

endpackage

// File: rtl/bowling_roll_sequencer_if.sv
// Bundle between the bowling front panel and the roll sequencer.
// master drives button/pointIn; slave returns roll events and game status.
interface bowling_roll_sequencer_if;
    import bowling_pkg::*;

    logic             button;
    logic [PIN_W-1:0] pointIn;
    logic             roll_valid;
    logic [PIN_W-1:0] roll_pins;
    logic [1:0]       roll_mult;
    logic [3:0]       frame;
    logic [1:0]       roll_idx;
    logic [PIN_W-1:0] pins_left;
    logic             strike;
    logic             spare;
    logic             bad_roll;
    logic             game_over;

    modport master (
        output button, pointIn,
        input  roll_valid, roll_pins, roll_mult, frame, roll_idx,
        input  pins_left, strike, spare, bad_roll, game_over
    );

    modport slave (
        input  button, pointIn,
        output roll_valid, roll_pins, roll_mult, frame, roll_idx,
        output pins_left, strike, spare, bad_roll, game_over
    );

endinterface

// File: rtl/bowling_button_qual.sv
// Roll button qualifier: 2-flop sync, rising-edge detect, lockout window.
// Ports: clk, reset (async high), button (raw), roll_evt (1-cycle pulse).
module bowling_button_qual #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic button,
    output logic roll_evt
);
    import bowling_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          sync3;
    logic [CW-1:0] lock;

    // Edge only counts once the previous lockout has fully expired.
    assign roll_evt = sync2 & ~sync3 & (lock == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            sync3 <= 1'b0;
            lock  <= '0;
        end else begin
            sync1 <= button;
            sync2 <= sync1;
            sync3 <= sync2;
            if (roll_evt)
                lock <= CW'(DEBOUNCE_CYCLES - 1);
            else if (lock != '0)
                lock <= lock - CW'(1);
        end
    end

endmodule

// File: rtl/bowling_roll_sequencer.sv
// Roll sequencer: qualifies rolls, tracks frame/roll, validates pins, tags mult.
// Ports: clk, reset (async high), bus (slave: button/pointIn in, roll status out).
module bowling_roll_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_PINS        = bowling_pkg::MAX_PINS,
    parameter int NUM_FRAMES      = bowling_pkg::NUM_FRAMES
) (
    input logic                     clk,
    input logic                     reset,
    bowling_roll_sequencer_if.slave bus
);
    import bowling_pkg::*;

    localparam logic [PIN_W-1:0] FULL_RACK = PIN_W'(MAX_PINS);
    localparam logic [3:0]       LAST_OPEN = 4'(NUM_FRAMES - 1);
    localparam logic [3:0]       TENTH     = 4'(NUM_FRAMES);

    logic             roll_evt;
    logic             evt_q;
    logic [PIN_W-1:0] pin_q;

    state_t           state, state_nx;
    logic [3:0]       frame_q, frame_nx;
    logic [PIN_W-1:0] pins_q, pins_nx;
    logic             rack_new, rack_new_nx;
    logic [1:0]       pend_next, pend_next_nx;
    logic [1:0]       pend_after, pend_after_nx;

    logic             accept;
    logic             reject;
    logic             clear;
    logic             strk;
    logic             spr;
    logic             in_bonus;

    logic             roll_valid_q;
    logic             bad_roll_q;
    logic             strike_q;
    logic             spare_q;
    logic [PIN_W-1:0] roll_pins_q;
    logic [1:0]       roll_mult_q;
    logic [1:0]       roll_idx_c;
    logic             game_over_c;

    bowling_button_qual #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_qual (
        .clk     (clk),
        .reset   (reset),
        .button  (bus.button),
        .roll_evt(roll_evt)
    );

    // pointIn is captured on the qualified edge; judged one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            evt_q <= 1'b0;
            pin_q <= '0;
        end else begin
            evt_q <= roll_evt;
            if (roll_evt)
                pin_q <= bus.pointIn;
        end
    end

    assign accept   = evt_q && (state != DONE) && (pin_q <= pins_q);
    assign reject   = evt_q && !accept;
    assign clear    = (pin_q == pins_q);
    // rack_new marks a full fresh rack, so clearing it is a strike.
    assign strk     = accept && rack_new && clear;
    assign spr      = accept && !rack_new && clear;
    assign in_bonus = (frame_q < TENTH);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= F_R1;
            frame_q    <= 4'd1;
            pins_q     <= FULL_RACK;
            rack_new   <= 1'b1;
            pend_next  <= 2'd0;
            pend_after <= 2'd0;
        end else begin
            state      <= state_nx;
            frame_q    <= frame_nx;
            pins_q     <= pins_nx;
            rack_new   <= rack_new_nx;
            pend_next  <= pend_next_nx;
            pend_after <= pend_after_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        frame_nx      = frame_q;
        pins_nx       = pins_q;
        rack_new_nx   = rack_new;
        pend_next_nx  = pend_next;
        pend_after_nx = pend_after;
        if (accept) begin
            pins_nx     = clear ? FULL_RACK : pins_q - pin_q;
            rack_new_nx = clear;
            if (in_bonus) begin
                pend_next_nx  = pend_after + {1'b0, strk} + {1'b0, spr};
                pend_after_nx = {1'b0, strk};
            end else begin
                pend_next_nx  = pend_after;
                pend_after_nx = 2'd0;
            end
            unique case (state)
                F_R1: begin
                    if (clear) begin
                        frame_nx = frame_q + 4'd1;
                        state_nx = (frame_q == LAST_OPEN) ? T_R1 : F_R1;
                    end else begin
                        state_nx = F_R2;
                    end
                end
                F_R2: begin
                    frame_nx    = frame_q + 4'd1;
                    pins_nx     = FULL_RACK;
                    rack_new_nx = 1'b1;
                    state_nx    = (frame_q == LAST_OPEN) ? T_R1 : F_R1;
                end
                T_R1: state_nx = T_R2;
                // A fill ball is earned by a first-ball strike or a spare.
                T_R2: state_nx = (rack_new || clear) ? T_R3 : DONE;
                T_R3: state_nx = DONE;
                default: state_nx = state;
            endcase
        end
    end

    always_comb begin
        roll_idx_c  = 2'd0;
        game_over_c = 1'b0;
        unique case (state)
            F_R1, T_R1: roll_idx_c = 2'd0;
            F_R2, T_R2: roll_idx_c = 2'd1;
            T_R3:       roll_idx_c = 2'd2;
            DONE:       game_over_c = 1'b1;
            default:    roll_idx_c = 2'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            roll_valid_q <= 1'b0;
            bad_roll_q   <= 1'b0;
            strike_q     <= 1'b0;
            spare_q      <= 1'b0;
            roll_pins_q  <= '0;
            roll_mult_q  <= 2'd1;
        end else begin
            roll_valid_q <= accept;
            bad_roll_q   <= reject;
            strike_q     <= strk;
            spare_q      <= spr;
            if (accept) begin
                roll_pins_q <= pin_q;
                roll_mult_q <= 2'd1 + pend_next;
            end
        end
    end

    assign bus.roll_valid = roll_valid_q;
    assign bus.roll_pins  = roll_pins_q;
    assign bus.roll_mult  = roll_mult_q;
    assign bus.frame      = frame_q;
    assign bus.roll_idx   = roll_idx_c;
    assign bus.pins_left  = pins_q;
    assign bus.strike     = strike_q;
    assign bus.spare      = spare_q;
    assign bus.bad_roll   = bad_roll_q;
    assign bus.game_over  = game_over_c;

endmodule
